sync_fifo: RTL and testbench



---
 rtl/wrd_pkg.sv | 20 ++
 rtl/sync_fifo_mem.sv | 31 +++
 rtl/sync_fifo.sv | 91 +++++++++
 tb/tb_sync_fifo.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wrd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wrd_pkg
// Brief    : Shared word-recognition datapath constants and sizing helpers.
// Revision : 1.0
// ============================================================================
package wrd_pkg;

    localparam int WRD_BW         = 8;
    localparam int WRD_FRAME_SIZE = 50;

    // A one-entry-wide pointer is still needed when the depth collapses to 1.
    function automatic int wrd_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int WRD_PTR_W = wrd_ptr_w(WRD_FRAME_SIZE);

endpackage : wrd_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mem
// Brief    : FIFO storage array, registered write and asynchronous read; not reset.
// Revision : 1.0
// ============================================================================
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 50,
    parameter int ADDR_W     = 6
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FWFT circular FIFO; define FIFO_CHECK_EN for
//            simulation overflow/underflow checks.
// Revision : 1.0
// ============================================================================
module sync_fifo
    import wrd_pkg::*;
#(
    parameter int DATA_WIDTH = WRD_BW,
    parameter int FIFO_DEPTH = WRD_FRAME_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i_n,
    input  logic                  enq_i,
    input  logic                  deq_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o_n,
    output logic                  empty_o_n
);

    localparam int                  c_PTR_W    = wrd_ptr_w(FIFO_DEPTH);
    localparam int                  c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_do_enq;
    logic                  w_do_deq;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign empty_o_n = (r_count != '0);
    assign full_o_n  = (r_count != c_CNT_FULL);

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_do_enq = enq_i & (full_o_n | deq_i);
    assign w_do_deq = deq_i & empty_o_n;

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_deq) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (c_PTR_W)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_do_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (din_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Storage is never reset, so an empty FIFO must mask stale head data.
    assign dout_o = empty_o_n ? w_rd_data : '0;

`ifdef FIFO_CHECK_EN
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i_n)
        !(enq_i && !full_o_n && !deq_i))
        else $error("sync_fifo: write while full dropped");

    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_i_n)
        !(deq_i && !empty_o_n))
        else $error("sync_fifo: read while empty ignored");
`else
`endif

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Scoreboard bench for sync_fifo against a queue-based reference.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 50;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          enq   = 1'b0;
    logic          deq   = 1'b0;
    logic [DW-1:0] din   = '0;
    logic [DW-1:0] dout;
    logic          full_n;
    logic          empty_n;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          ne;
        logic          nf;
        logic [DW-1:0] head;
    } obs_t;

    logic [DW-1:0] ref_q [$];
    obs_t          exp_q [$];

    sync_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i_n   (rst_n),
        .enq_i     (enq),
        .deq_i     (deq),
        .din_i     (din),
        .dout_o    (dout),
        .full_o_n  (full_n),
        .empty_o_n (empty_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue; reset discards it immediately.
    always @(negedge rst_n) ref_q.delete();

    always @(posedge clk) begin
        obs_t o;
        bit   dd;
        bit   de;
        if (rst_n) begin
            dd = deq && (ref_q.size() > 0);
            de = enq && ((ref_q.size() < DEPTH) || deq);
            if (dd) void'(ref_q.pop_front());
            if (de) ref_q.push_back(din);
        end
        o.ne   = (ref_q.size() != 0);
        o.nf   = (ref_q.size() != DEPTH);
        o.head = (ref_q.size() != 0) ? ref_q[0] : '0;
        exp_q.push_back(o);
    end

    // Monitor: one expected observation per clock edge, compared half a cycle later.
    always @(negedge clk) begin
        obs_t o;
        if (exp_q.size() > 0) begin
            o = exp_q.pop_front();
            chk("empty_o_n", 32'(empty_n), 32'(o.ne));
            chk("full_o_n",  32'(full_n),  32'(o.nf));
            chk("dout_o",    32'(dout),    32'(o.head));
        end
    end

    task automatic drive(input logic e, input logic d, input logic [DW-1:0] v);
        @(negedge clk);
        enq = e;
        deq = d;
        din = v;
    endtask

    initial begin
        int p_enq;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle, then a deq on empty.
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);

        // Single word through.
        drive(1, 0, 8'h11);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);

        // Fill, drop on full, drain in order.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(i));
        drive(1, 0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);
        drive(0, 0, 0);

        // Enq + deq while full, then drain.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(i));
        drive(1, 1, 8'h77);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 8'h3C);
        drive(0, 0, 0);
        drive(0, 1, 0);

        // Circulate the head back to the tail across pointer wrap.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(i));
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            enq = 1'b1;
            deq = 1'b1;
            din = dout;
        end
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);

        // Randomized traffic with a drifting enqueue bias.
        p_enq = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) p_enq = int'($urandom_range(15, 90));
            drive(($urandom_range(0, 99) < p_enq), ($urandom_range(0, 99) < (105 - p_enq)),
                  8'($urandom));
        end

        // Asynchronous reset mid-fill.
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 8'(8'hC0 + i));
        drive(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_empty_n", 32'(empty_n), 32'd0);
        chk("async_rst_full_n",  32'(full_n),  32'd1);
        chk("async_rst_dout",    32'(dout),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 8'h5A);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
